vblank_update_arbiter: RTL and testbench
========================================

Name: vblank_update_arbiter

Overview:
- Schedules access to shared display state (board RAM, counter and timer registers) among several update requesters.
- Grants are issued only inside the vertical-blanking window, so the draw pipeline never reads half-updated state during active video.
- Sits beside the VGA timing generator and consumes its vblnk/vcount outputs.
- Arbitration is round-robin, one grant at a time, with forced revocation when the window closes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- VCOUNT_MAX, 925, last line index of the frame (VER_TOTAL_TIME-1 for 1440x900@60).
- GUARD_LINES, 2, lines at the end of vblank in which no grant may be active.
- MAX_HOLD, 4096, maximum cycles a single grant may be held before forced revoke.

Ports:
- clk  input  1  pixel clock (88.75 MHz)
- rst  input  1  asynchronous reset, active-high
- vblnk  input  1  vertical blanking from the timing generator
- vcount  input  11  current line from the timing generator
- req  input  NUM_REQ  per-requester access request, level
- done  input  NUM_REQ  per-requester 1-cycle release pulse
- gnt  output  NUM_REQ  one-hot grant (all-zero when idle)
- busy  output  1  a grant is active
- window_open  output  1  registered update window
- revoke  output  1  1-cycle pulse when a grant is forcibly removed
- frame_tick  output  1  1-cycle pulse on window opening

Behaviour:
- Reset (async, rst=1): gnt=0, busy=0, window_open=0, revoke=0, frame_tick=0, hold counter=0, state=IDLE. The round-robin pointer is set so that requester 0 has highest priority.
- window_open is registered: next value = vblnk && (vcount <= VCOUNT_MAX-GUARD_LINES). With defaults it is high for lines 900..923, one cycle after the inputs.
- frame_tick: 1-cycle pulse in the cycle after window_open rises (registered edge detect).
- FSM states IDLE, GRANT.
  - IDLE: if window_open && |req, select the first set req scanning upward from (last granted index + 1) modulo NUM_REQ. gnt becomes one-hot on the next cycle, busy=1, hold counter cleared, go to GRANT. Otherwise gnt stays 0.
  - GRANT:
    - Release when done[g]=1 or req[g]=0 (g = granted index). gnt=0 and busy=0 on the next cycle, pointer=g, return to IDLE.
    - Forced revoke when window_open=0 or the hold counter reaches MAX_HOLD-1. gnt=0 on the next cycle, revoke=1 for exactly that cycle, pointer=g, return to IDLE.
    - Otherwise the hold counter increments and the grant is held.
- After every release or revoke, IDLE lasts at least one cycle before the next grant is issued (one-cycle bus turnaround).
- Release and revoke conditions in the same cycle: release wins and no revoke pulse is generated.
- done on a non-granted index and req changes on non-granted indices: ignored.
- The hold counter is $clog2(MAX_HOLD) bits wide, saturates at MAX_HOLD-1 and is cleared on each new grant.
- gnt is always zero or one-hot. gnt!=0 implies window_open was 1 in the cycle the grant was issued.
- Reset mid-grant: gnt drops immediately (async) and the pointer returns to its reset value.
- Requests arriving outside the window are held pending by the requester (level req). They are granted in the first IDLE cycle after window_open=1.

Test Plan:
- req=4'b0101 asserted at vcount=500, vblnk=0 -> gnt stays 0. At vcount=900 with vblnk=1: window_open=1 one cycle later, gnt=4'b0001 the cycle after, frame_tick pulses once.
- Requester 0 pulses done while req=4'b0101 -> gnt=0 for one cycle, then gnt=4'b0100. After requester 2 releases, the next grant goes to requester 0 (round-robin wrap).
- Hold a grant across vcount=924 -> window_open falls, gnt=0 the next cycle, revoke=1 for exactly one cycle. No new grant is issued until line 900 of the next frame.
- Hold a grant with req high and no done for MAX_HOLD=16 (override) cycles inside the window -> gnt clears after 16 cycles, revoke pulses, the next pending requester is granted after one idle cycle.
- done on the granted index in the same cycle window_open falls -> gnt clears, revoke stays 0.
- Assert rst while gnt=4'b0010 -> gnt, busy and window_open go to 0 asynchronously. After rst is released with req=4'b1111 in-window, the first grant is 4'b0001.

Source files
------------

// File: rtl/vblank_update_arbiter_if.sv
// Bus between the vblank update arbiter and its surroundings.
// The timing-generator inputs (vblnk, vcount) and the requester handshake
// (req, done) go into the arbiter. The grant and status outputs
// (gnt, busy, window_open, revoke, frame_tick) come back out.
//   master : requester / timing side, drives vblnk, vcount, req, done
//   slave  : arbiter side, drives gnt, busy, window_open, revoke, frame_tick
interface vblank_update_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic               vblnk;
  logic [10:0]        vcount;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               window_open;
  logic               revoke;
  logic               frame_tick;

  modport master (
    output vblnk, vcount, req, done,
    input  gnt, busy, window_open, revoke, frame_tick
  );

  modport slave (
    input  vblnk, vcount, req, done,
    output gnt, busy, window_open, revoke, frame_tick
  );
endinterface

// File: rtl/vblank_update_arbiter.sv
// Round-robin arbiter for access to the shared display state. Grants are
// issued only while the registered update window is open. The window is the
// vertical blanking interval minus the last GUARD_LINES lines. A grant is
// forcibly revoked when the window closes or when it has been held too long.
//   clk  : pixel clock
//   rst  : asynchronous reset, active-high
//   bus  : slave modport, carrying these signals:
//          vblnk/vcount in, req/done in, gnt/busy/window_open/revoke/frame_tick out
//
// state | meaning
// IDLE  | no grant active; a grant may be issued when the window is open
// GRANT | exactly one requester holds the shared state
module vblank_update_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int VCOUNT_MAX  = 925,
  parameter int GUARD_LINES = 2,
  parameter int MAX_HOLD    = 4096
) (
  input logic                   clk,
  input logic                   rst,
  vblank_update_arbiter_if.slave bus
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(MAX_HOLD);
  localparam logic [10:0]     WIN_LAST  = 11'(VCOUNT_MAX - GUARD_LINES);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);
  // The pointer holds the last granted index. Resetting it to the top index
  // makes requester 0 the first candidate in the scan.
  localparam logic [IDXW-1:0] PTR_RESET = IDXW'(NUM_REQ - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] gnt_q, gnt_nxt;
  logic               busy_q, busy_nxt;
  logic               revoke_q, revoke_nxt;
  logic [IDXW-1:0]    last_q, last_nxt;
  logic [IDXW-1:0]    cur_q, cur_nxt;
  logic [CNTW-1:0]    hold_q, hold_nxt;
  logic               win_q, win_d, tick_q;
  logic               win_nxt;
  logic               sel_found;
  logic [IDXW-1:0]    sel_idx;
  logic               release_now, force_now;

  function automatic logic [IDXW-1:0] wrap_idx(input int unsigned v);
    return IDXW'(v % NUM_REQ);
  endfunction

  assign win_nxt = bus.vblnk && (bus.vcount <= WIN_LAST);

  // First pending request scanning upward from last granted index + 1.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      if (!sel_found && bus.req[wrap_idx(32'(last_q) + i)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_idx(32'(last_q) + i);
      end
    end
  end

  assign release_now = bus.done[cur_q] || !bus.req[cur_q];
  assign force_now   = !win_q || (hold_q == HOLD_LAST);

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt_q;
    busy_nxt   = busy_q;
    revoke_nxt = 1'b0;
    last_nxt   = last_q;
    cur_nxt    = cur_q;
    hold_nxt   = hold_q;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (win_q && sel_found) begin
          state_nxt        = GRANT;
          gnt_nxt[sel_idx] = 1'b1;
          busy_nxt         = 1'b1;
          cur_nxt          = sel_idx;
          hold_nxt         = '0;
        end
      end
      GRANT: begin
        // A voluntary release takes priority over a forced revoke.
        // Either way the next cycle is IDLE, which gives the bus turnaround.
        if (release_now || force_now) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          busy_nxt   = 1'b0;
          last_nxt   = cur_q;
          revoke_nxt = !release_now;
        end else begin
          // The revoke fires at HOLD_LAST, so the counter never wraps.
          hold_nxt = hold_q + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      revoke_q <= 1'b0;
      last_q   <= PTR_RESET;
      cur_q    <= '0;
      hold_q   <= '0;
      win_q    <= 1'b0;
      win_d    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt_q    <= gnt_nxt;
      busy_q   <= busy_nxt;
      revoke_q <= revoke_nxt;
      last_q   <= last_nxt;
      cur_q    <= cur_nxt;
      hold_q   <= hold_nxt;
      win_q    <= win_nxt;
      win_d    <= win_q;
      tick_q   <= win_q && !win_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.busy        = busy_q;
  assign bus.window_open = win_q;
  assign bus.revoke      = revoke_q;
  assign bus.frame_tick  = tick_q;

endmodule

// File: tb/tb_vblank_update_arbiter.sv
// Self-checking bench for vblank_update_arbiter. Table rows and hand-written
// sequences drive inputs on the falling edge and push the expected outputs
// for the following rising edge into a queue. A monitor pops each entry and
// compares it shortly after that rising edge.
module tb_vblank_update_arbiter;
  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vblank_update_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  vblank_update_arbiter #(
    .NUM_REQ(NUM_REQ), .VCOUNT_MAX(925), .GUARD_LINES(2), .MAX_HOLD(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       busy;
    logic       win;
    logic       rev;
    logic       tick;
  } exp_t;

  typedef struct {
    logic        vblnk;
    logic [10:0] vc;
    logic [3:0]  req;
    logic [3:0]  done;
    exp_t        exp;
  } vec_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step  = 0;
  vec_t tbl[19];

  function automatic vec_t mk(input logic vb, input int vc, input logic [3:0] rq,
                              input logic [3:0] dn, input logic [3:0] g,
                              input logic b, input logic w, input logic r,
                              input logic t);
    vec_t v;
    v.vblnk = vb;
    v.vc    = 11'(vc);
    v.req   = rq;
    v.done  = dn;
    v.exp   = '{gnt: g, busy: b, win: w, rev: r, tick: t};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    bus.vblnk  = v.vblnk;
    bus.vcount = v.vc;
    bus.req    = v.req;
    bus.done   = v.done;
    sb_q.push_back(v.exp);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    exp_t a;
    a = {bus.gnt, bus.busy, bus.window_open, bus.revoke, bus.frame_tick};
    total++;
    if (a !== '0) begin
      bad++;
      $display("FAIL %s: got gnt=%b busy=%b win=%b rev=%b tick=%b, want all 0",
               name, a.gnt, a.busy, a.win, a.rev, a.tick);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = sb_q.pop_front();
      a = {bus.gnt, bus.busy, bus.window_open, bus.revoke, bus.frame_tick};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL step%0d: got gnt=%b busy=%b win=%b rev=%b tick=%b, want gnt=%b busy=%b win=%b rev=%b tick=%b",
                 step, a.gnt, a.busy, a.win, a.rev, a.tick,
                 e.gnt, e.busy, e.win, e.rev, e.tick);
      end
      step++;
    end
    if (!rst) begin
      total++;
      if (!$onehot0(bus.gnt)) begin
        bad++;
        $display("FAIL onehot: got gnt=%b, want zero or one-hot", bus.gnt);
      end
    end
  end

  initial begin
    //               vb  vc   req      done     gnt      bsy win rev tck
    tbl[0]  = mk(1'b0, 500, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[1]  = mk(1'b0, 500, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[2]  = mk(1'b1, 900, 4'b0101, 4'b0000, 4'b0000, 0, 1, 0, 0);
    tbl[3]  = mk(1'b1, 901, 4'b0101, 4'b0000, 4'b0001, 1, 1, 0, 1);
    tbl[4]  = mk(1'b1, 902, 4'b0101, 4'b0000, 4'b0001, 1, 1, 0, 0);
    tbl[5]  = mk(1'b1, 903, 4'b0101, 4'b0001, 4'b0000, 0, 1, 0, 0);
    tbl[6]  = mk(1'b1, 904, 4'b0101, 4'b0000, 4'b0100, 1, 1, 0, 0);
    tbl[7]  = mk(1'b1, 905, 4'b0101, 4'b0100, 4'b0000, 0, 1, 0, 0);
    tbl[8]  = mk(1'b1, 906, 4'b0101, 4'b0000, 4'b0001, 1, 1, 0, 0);
    tbl[9]  = mk(1'b1, 907, 4'b0100, 4'b0000, 4'b0000, 0, 1, 0, 0);
    tbl[10] = mk(1'b1, 908, 4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 0);
    tbl[11] = mk(1'b1, 923, 4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 0);
    tbl[12] = mk(1'b1, 924, 4'b0100, 4'b0000, 4'b0100, 1, 0, 0, 0);
    tbl[13] = mk(1'b1, 925, 4'b0100, 4'b0000, 4'b0000, 0, 0, 1, 0);
    tbl[14] = mk(1'b0,   0, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[15] = mk(1'b0, 500, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[16] = mk(1'b0, 899, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 0);
    tbl[17] = mk(1'b1, 900, 4'b0101, 4'b0000, 4'b0000, 0, 1, 0, 0);
    tbl[18] = mk(1'b1, 901, 4'b0101, 4'b0000, 4'b0001, 1, 1, 0, 1);

    rst        = 1'b1;
    bus.vblnk  = 1'b0;
    bus.vcount = '0;
    bus.req    = '0;
    bus.done   = '0;
    #12;
    check_idle_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Window gating, frame tick, release, round-robin wrap, window-close revoke
    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // Hold limit: requester 0 keeps the grant for 16 cycles in total, then it is revoked
    for (int i = 0; i < 15; i++)
      apply(mk(1'b1, 910, 4'b0101, 4'b0000, 4'b0001, 1, 1, 0, 0));
    apply(mk(1'b1, 910, 4'b0101, 4'b0000, 4'b0000, 0, 1, 1, 0));
    apply(mk(1'b1, 910, 4'b0101, 4'b0000, 4'b0100, 1, 1, 0, 0));

    // done on a non-granted index is ignored; release beats revoke at window close
    apply(mk(1'b1, 911, 4'b0101, 4'b0001, 4'b0100, 1, 1, 0, 0));
    apply(mk(1'b1, 924, 4'b0101, 4'b0000, 4'b0100, 1, 0, 0, 0));
    apply(mk(1'b1, 925, 4'b0101, 4'b0100, 4'b0000, 0, 0, 0, 0));
    apply(mk(1'b0,   0, 4'b0101, 4'b0000, 4'b0000, 0, 0, 0, 0));

    // Grant requester 1, then reset in the middle of the grant
    apply(mk(1'b1, 900, 4'b0010, 4'b0000, 4'b0000, 0, 1, 0, 0));
    apply(mk(1'b1, 901, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0, 1));
    drain();
    #1;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    bus.vblnk  = 1'b1;
    bus.vcount = 11'd900;
    bus.req    = 4'b1111;
    bus.done   = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply(mk(1'b1, 901, 4'b1111, 4'b0000, 4'b0001, 1, 1, 0, 1));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation still running at 50000, want finish earlier");
    $fatal(1);
  end

endmodule
